// File: rtl/dsp_mac_pipe.sv
// Signed pre-adder -> multiplier -> post-adder/accumulator slice with valid/ready
// flow control, optional round-half-up shift of the product, saturation and a
// sticky overflow flag. Every stage (valid bits included) advances together, or
// not at all.
module dsp_mac_pipe #(
    parameter int unsigned A_WIDTH     = 18,
    parameter int unsigned B_WIDTH     = 18,
    parameter int unsigned C_WIDTH     = 48,
    parameter int unsigned P_WIDTH     = 48,
    parameter int unsigned MULT_STAGES = 2,
    parameter int unsigned RND_SHIFT   = 0,
    parameter bit          SAT_EN      = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [A_WIDTH-1:0] a,
    input  logic signed [B_WIDTH-1:0] b,
    input  logic signed [B_WIDTH-1:0] d,
    input  logic signed [C_WIDTH-1:0] c,
    input  logic        [4:0]         opmode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [P_WIDTH-1:0] p,
    output logic                      ovf
);

    localparam int unsigned PRE_W  = B_WIDTH + 1;
    localparam int unsigned PROD_W = A_WIDTH + B_WIDTH + 1;
    localparam int unsigned LAST   = MULT_STAGES - 1;

    localparam logic signed [P_WIDTH-1:0] P_MAX    = {1'b0, {(P_WIDTH-1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] P_MIN    = {1'b1, {(P_WIDTH-1){1'b0}}};
    // Half an LSB of the shifted result; zero when no shift is configured.
    localparam logic signed [P_WIDTH-1:0] RND_HALF = P_WIDTH'((64'd1 << RND_SHIFT) >> 1);

    logic adv;

    // S0: input register
    logic                      v0_q;
    logic signed [A_WIDTH-1:0] a0_q;
    logic signed [B_WIDTH-1:0] b0_q, d0_q;
    logic signed [C_WIDTH-1:0] c0_q;
    logic        [4:0]         op0_q;

    // S1: pre-adder register
    logic                      v1_q;
    logic signed [A_WIDTH-1:0] a1_q;
    logic signed [PRE_W-1:0]   pre1_q;
    logic signed [C_WIDTH-1:0] c1_q;
    logic        [4:0]         op1_q;

    // Multiplier stages
    logic                      vm_q   [MULT_STAGES];
    logic signed [PROD_W-1:0]  prod_q [MULT_STAGES];
    logic signed [C_WIDTH-1:0] cm_q   [MULT_STAGES];
    logic        [4:0]         opm_q  [MULT_STAGES];

    // Final stage
    logic                      out_valid_q;
    logic signed [P_WIDTH-1:0] p_q;
    logic                      ovf_q;

    logic signed [PRE_W-1:0]   b_ext, d_ext, pre_d;
    logic signed [PROD_W-1:0]  a_ext, m_in, prod_d;
    logic signed [P_WIDTH-1:0] prod_ext, m, z, c_ext, p_d;
    logic signed [P_WIDTH:0]   z_x, m_x, sum;
    logic                      ovf_now, ovf_d;

    // A stalled output blocks the whole pipe; anything else lets it move.
    always_comb begin
        adv      = out_ready | ~out_valid_q;
        in_ready = adv;
    end

    // Pre-adder at full B_WIDTH+1 precision
    always_comb begin
        b_ext = PRE_W'(b0_q);
        d_ext = PRE_W'(d0_q);
        pre_d = b_ext;
        if (op0_q[0]) begin
            pre_d = op0_q[1] ? (d_ext - b_ext) : (d_ext + b_ext);
        end
    end

    // Full-precision signed product
    always_comb begin
        a_ext  = PROD_W'(a1_q);
        m_in   = PROD_W'(pre1_q);
        prod_d = a_ext * m_in;
    end

    // Rounding, operand select, post-adder, overflow detect and saturation
    always_comb begin
        prod_ext = P_WIDTH'(prod_q[LAST]);
        m        = (prod_ext + RND_HALF) >>> RND_SHIFT;
        c_ext    = P_WIDTH'(cm_q[LAST]);
        z        = c_ext;
        if (opm_q[LAST][4]) begin
            z = '0;
        end else if (opm_q[LAST][2]) begin
            z = p_q;
        end
        z_x     = {z[P_WIDTH-1], z};
        m_x     = {m[P_WIDTH-1], m};
        sum     = opm_q[LAST][3] ? (z_x - m_x) : (z_x + m_x);
        ovf_now = sum[P_WIDTH] ^ sum[P_WIDTH-1];
        p_d     = sum[P_WIDTH-1:0];
        if (SAT_EN && ovf_now) begin
            p_d = sum[P_WIDTH] ? P_MIN : P_MAX;
        end
        // A fresh overflow wins over the clear carried by the same item.
        ovf_d = (opm_q[LAST][4] ? 1'b0 : ovf_q) | ovf_now;
    end

    // S0 and S1 registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            a0_q   <= '0;
            b0_q   <= '0;
            d0_q   <= '0;
            c0_q   <= '0;
            op0_q  <= '0;
            v1_q   <= 1'b0;
            a1_q   <= '0;
            pre1_q <= '0;
            c1_q   <= '0;
            op1_q  <= '0;
        end else if (adv) begin
            v0_q   <= in_valid;
            a0_q   <= a;
            b0_q   <= b;
            d0_q   <= d;
            c0_q   <= c;
            op0_q  <= opmode;
            v1_q   <= v0_q;
            a1_q   <= a0_q;
            pre1_q <= pre_d;
            c1_q   <= c0_q;
            op1_q  <= op0_q;
        end
    end

    // Multiplier pipeline; C and OPMODE ride alongside their product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MULT_STAGES); i++) begin
                vm_q[i]   <= 1'b0;
                prod_q[i] <= '0;
                cm_q[i]   <= '0;
                opm_q[i]  <= '0;
            end
        end else if (adv) begin
            vm_q[0]   <= v1_q;
            prod_q[0] <= prod_d;
            cm_q[0]   <= c1_q;
            opm_q[0]  <= op1_q;
            for (int i = 1; i < int'(MULT_STAGES); i++) begin
                vm_q[i]   <= vm_q[i-1];
                prod_q[i] <= prod_q[i-1];
                cm_q[i]   <= cm_q[i-1];
                opm_q[i]  <= opm_q[i-1];
            end
        end
    end

    // Result register: bubbles leave P and OVF untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vm_q[LAST];
            if (vm_q[LAST]) begin
                p_q   <= p_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed bench for dsp_mac_pipe: default instance plus a RND_SHIFT=2 instance.
// Expected results are queued at drive time and checked whenever OUT_VALID is high.
module tb_dsp_mac_pipe;

    localparam int PW = 48;

    typedef struct packed {
        logic [PW-1:0] p;
        logic          ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default instance
    logic                 in_valid, in_ready, out_valid, ovf;
    logic                 out_ready = 1'b1;
    logic signed [17:0]   a, b, d;
    logic signed [PW-1:0] c, p;
    logic        [4:0]    opmode;

    // Rounding instance
    logic                 in_valid_r, in_ready_r, out_valid_r, ovf_r;
    logic                 out_ready_r;
    logic signed [17:0]   a_r, b_r, d_r;
    logic signed [PW-1:0] c_r, p_r;
    logic        [4:0]    opmode_r;

    exp_t q[$];
    exp_t q_r[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic       bp_en = 1'b0;
    logic [3:0] bp_pat = 4'b1001;
    int         bp_idx = 0;

    dsp_mac_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .d        (d),
        .c        (c),
        .opmode   (opmode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .p        (p),
        .ovf      (ovf)
    );

    dsp_mac_pipe #(
        .RND_SHIFT(2)
    ) dut_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_r),
        .in_ready (in_ready_r),
        .a        (a_r),
        .b        (b_r),
        .d        (d_r),
        .c        (c_r),
        .opmode   (opmode_r),
        .out_valid(out_valid_r),
        .out_ready(out_ready_r),
        .p        (p_r),
        .ovf      (ovf_r)
    );

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // out_ready pattern 1,0,0,1,... while backpressure is enabled
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            out_ready = bp_pat[bp_idx % 4];
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Scoreboard for the default instance; P must match the head item for as long as it is shown
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    chk("p", p, q[0].p);
                    chk("ovf", ovf, q[0].ovf);
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Scoreboard for the rounding instance
    always @(negedge clk) begin
        if (rst_n && out_valid_r) begin
            if (q_r.size() == 0) begin
                chk("spurious_out_r", out_valid_r, 1'b0);
            end else begin
                chk("p_r", p_r, q_r[0].p);
                chk("ovf_r", ovf_r, q_r[0].ovf);
                if (out_ready_r) void'(q_r.pop_front());
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present one item and hold it until accepted; returns 1 ns after the accepting edge
    task automatic send(input logic signed [17:0] av, input logic signed [17:0] bv,
                        input logic signed [17:0] dv, input logic signed [PW-1:0] cv,
                        input logic [4:0] op, input logic signed [PW-1:0] ep, input logic eo);
        logic acc;
        int   n;
        a = av; b = bv; d = dv; c = cv; opmode = op; in_valid = 1'b1;
        q.push_back('{p: ep, ovf: eo});
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send_r(input logic signed [17:0] av, input logic signed [17:0] bv,
                          input logic signed [PW-1:0] ep);
        logic acc;
        int   n;
        a_r = av; b_r = bv; d_r = '0; c_r = '0; opmode_r = 5'b00000; in_valid_r = 1'b1;
        q_r.push_back('{p: ep, ovf: 1'b0});
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready_r;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("accept_timeout_r", acc, 1'b1);
        in_valid_r = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || q_r.size() != 0) && n < 200) begin
            sync();
            n++;
        end
        chk("drain", 1'((q.size() == 0) && (q_r.size() == 0)), 1'b1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; d = '0; c = '0; opmode = '0;
        in_valid_r = 1'b0; a_r = '0; b_r = '0; d_r = '0; c_r = '0; opmode_r = '0;
        out_ready_r = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_p", p, '0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_out_valid_r", out_valid_r, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1'b1);
        sync();

        // Basic MAC with latency check: valid appears after the 4th edge past acceptance
        send(18'sd3, 18'sd4, 18'sd0, 48'sd10, 5'b00000, 48'sd22, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            @(negedge clk);
            chk("latency", out_valid, 1'(j == 4));
        end
        sync();

        // Pre-adder variants
        send(18'sd2, 18'sd3, 18'sd10, 48'sd100, 5'b01011, 48'sd86, 1'b0);
        send(18'sd2, 18'sd3, 18'sd10, 48'sd100, 5'b00001, 48'sd126, 1'b0);
        drain();

        // Back-to-back accumulation: 5, 10, 15, 20 on consecutive cycles
        send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 5'b10000, 48'sd5, 1'b0);
        send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 5'b00100, 48'sd10, 1'b0);
        send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 5'b00100, 48'sd15, 1'b0);
        send(18'sd1, 18'sd5, 18'sd0, 48'sd0, 5'b00100, 48'sd20, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("acc_burst", out_valid, 1'b1);
        end
        sync();
        drain();

        // Saturation both ways, then clear
        send(18'sd1, 18'sd1, 18'sd0, 48'sh7FFF_FFFF_FFFF, 5'b00000, 48'sh7FFF_FFFF_FFFF, 1'b1);
        send(18'sd1, 18'sd1, 18'sd0, 48'sh8000_0000_0000, 5'b01000, 48'sh8000_0000_0000, 1'b1);
        send(18'sd1, 18'sd1, 18'sd0, 48'sd0, 5'b10000, 48'sd1, 1'b0);
        drain();

        // Backpressure stream
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(18'(i + 1), 18'sd2, 18'sd0, 48'(i * 100), 5'b00000,
                 48'(i * 100 + 2 * (i + 1)), 1'b0);
        end
        drain();
        bp_en = 1'b0;
        sync();

        // Rounding instance: 15->4, -15->-4, 6->2
        send_r(18'sd5, 18'sd3, 48'sd4);
        send_r(-18'sd5, 18'sd3, -48'sd4);
        send_r(18'sd1, 18'sd6, 48'sd2);
        drain();

        // Reset with three items in flight
        send_r(18'sd7, 18'sd7, 48'sd12);
        send_r(18'sd8, 18'sd8, 48'sd16);
        send_r(18'sd9, 18'sd9, 48'sd20);
        rst_n = 1'b0;
        #1;
        q_r.delete();
        chk("midrst_out_valid_r", out_valid_r, 1'b0);
        chk("midrst_p_r", p_r, '0);
        chk("midrst_ovf_r", ovf_r, 1'b0);
        chk("midrst_p", p, '0);
        sync();
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("post_rst_idle_r", out_valid_r, 1'b0);
        end
        sync();
        send_r(18'sd2, 18'sd2, 48'sd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised successor of the team's fixed-width DSP48A1-style slice.
- Signed pre-adder → multiplier → post-adder/accumulator, with configurable operand widths and multiplier pipeline depth.
- Adds valid/ready flow control with full-pipeline stall, optional rounding, saturation and a sticky overflow flag.
- Sits in filter/MAC datapaths and is chained stream-to-stream instead of through PCIN/PCOUT cascades.

Parameters:
- A_WIDTH, 18, signed A operand width.
- B_WIDTH, 18, signed B operand width; D uses the same width.
- C_WIDTH, 48, signed C addend width; sign-extended to P_WIDTH. C_WIDTH ≤ P_WIDTH.
- P_WIDTH, 48, result/accumulator width. Must be ≥ A_WIDTH+B_WIDTH+1.
- MULT_STAGES, 2, multiplier register stages; legal range 1..4.
- RND_SHIFT, 0, arithmetic right shift of the product with round-half-up; 0 means no shift.
- SAT_EN, 1, 1 = clamp on signed overflow; 0 = wrap.

Ports:
- CLK  in  1  clock; all registers on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input operand set valid.
- IN_READY  out  1  slice can accept this cycle.
- A  in  A_WIDTH  signed multiplicand.
- B  in  B_WIDTH  signed pre-adder operand / multiplier.
- D  in  B_WIDTH  signed pre-adder operand.
- C  in  C_WIDTH  signed post-adder operand.
- OPMODE  in  5  per-item mode, sampled with operands:
  - [0] PRE_EN: 1 = multiplier uses D±B; 0 = multiplier uses B.
  - [1] PRE_SUB: 1 = D−B; 0 = D+B.
  - [2] ACC: 1 = Z is P; 0 = Z is C.
  - [3] POST_SUB: 1 = Z−M; 0 = Z+M.
  - [4] CLR: Z=0 and clears OVF; overrides ACC.
- OUT_VALID  out  1  P holds a new result.
- OUT_READY  in  1  downstream accepts P.
- P  out  P_WIDTH  signed result / accumulator.
- OVF  out  1  sticky signed-overflow flag.

Behaviour:
- Reset (RSTN=0, asynchronous): all stage valid bits, P, OVF and every pipeline data register go to 0. Outputs OUT_VALID=0, P=0, OVF=0. IN_READY=1 once RSTN is deasserted.
- Stall control:
  - ADV = OUT_READY | ~OUT_VALID; IN_READY = ADV (combinational).
  - All stages, including valid bits, shift only when ADV=1; otherwise every register holds.
  - Bubbles propagate as valid=0 and never modify P or OVF.
- Stages, in order:
  - S0: input register (A, B, D, C, OPMODE).
  - S1: pre-adder register. Result is B_WIDTH+1 bits signed, full precision, no truncation.
  - S2..S(1+MULT_STAGES): signed product, A_WIDTH+B_WIDTH+1 bits, then the rounding shift.
  - Final: post-adder into the P register.
- Latency: an item accepted on edge k produces OUT_VALID=1 after edge k+MULT_STAGES+2 (MULT_STAGES+3 registers). Throughput is 1 item/cycle when OUT_READY=1.
- C and OPMODE travel with their item through the pipeline and are applied at the final stage.
- Rounding (RND_SHIFT>0): M = (prod + 2^(RND_SHIFT−1)) >>> RND_SHIFT, then sign-extended to P_WIDTH.
- Post-adder:
  - Computed in P_WIDTH+1 bits. Overflow = the two top bits differ.
  - SAT_EN=1: on overflow, P = +max (2^(P_WIDTH−1)−1) or −max (−2^(P_WIDTH−1)), chosen by the sign of the true result.
  - SAT_EN=0: P takes the low P_WIDTH bits.
  - Either mode: OVF is set on overflow and stays set.
- ACC=1 uses the current P register, i.e. the previous valid result. Back-to-back accumulation at full rate is exact.
- CLR=1: Z=0 and OVF is cleared. If the same item overflows, OVF ends set; set wins over clear.
- P and OVF update only when a valid item leaves the final stage with ADV=1. With OUT_VALID=1 and OUT_READY=0, P holds stable.
- Reset mid-operation: all in-flight items are discarded; there is no partial output after RSTN rises.

Test Plan:
- Basic MAC, defaults: A=3, B=4, C=10, OPMODE=0, OUT_READY=1, accepted at edge 0 → OUT_VALID after edge 4, P=22, OVF=0.
- Pre-adder and subtract: A=2, D=10, B=3, C=100.
  - OPMODE=5'b01011 (PRE_EN, PRE_SUB, POST_SUB) → P=100−14=86.
  - OPMODE=5'b00001 → P=100+26=126.
- Accumulate: 4 back-to-back items A=1, B=5.
  - First item CLR=1, remaining three ACC=1.
  - Consecutive P values 5, 10, 15, 20 on consecutive cycles.
- Saturation: SAT_EN=1, C=2^47−1, A=1, B=1, OPMODE=0 → P=2^47−1 and OVF=1. A next item with CLR=1, A=B=1 → P=1, OVF=0.
- Backpressure: stream 8 items with OUT_READY toggling 1,0,0,1,… → no item lost or duplicated. IN_READY=0 exactly while OUT_VALID=1 and OUT_READY=0. P stable during stall.
- Rounding and reset: instance with RND_SHIFT=2, A=5, B=3, C=0 → P=4.
  - Then assert RSTN=0 with 3 items in flight → OUT_VALID, P and OVF are 0 immediately.
  - No output appears after release until new input is accepted.
